// File: rtl/ahb_interconnect_p.sv
// AHB interconnect: address/control mux, address-map decode, data-phase muxes and a built-in
// two-cycle ERROR default slave. Define AHB_SPLIT_EN to register the OR of the slave split vectors.
module ahb_interconnect_p #(
  parameter int N_MASTER = 3,
  parameter int W_MASTER = 2,
  parameter int N_SLAVE  = 8,
  parameter int W_ADDR   = 32,
  parameter int W_DATA   = 32,
  parameter logic [N_SLAVE*W_ADDR-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVE*W_ADDR-1:0] SLV_MASK = '0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [W_MASTER-1:0]          HMASTER,
  input  logic [2*N_MASTER-1:0]        m_HTRANS,
  input  logic [3*N_MASTER-1:0]        m_HBURST,
  input  logic [3*N_MASTER-1:0]        m_HSIZE,
  input  logic [W_ADDR*N_MASTER-1:0]   m_HADDR,
  input  logic [N_MASTER-1:0]          m_HWRITE,
  input  logic [W_DATA*N_MASTER-1:0]   m_HWDATA,
  input  logic [N_SLAVE-1:0]           s_HREADY,
  input  logic [2*N_SLAVE-1:0]         s_HRESP,
  input  logic [W_DATA*N_SLAVE-1:0]    s_HRDATA,
  input  logic [N_MASTER*N_SLAVE-1:0]  s_HSPLIT,
  output logic [N_SLAVE-1:0]           HSEL,
  output logic [1:0]                   HTRANS,
  output logic [2:0]                   HBURST,
  output logic [2:0]                   HSIZE,
  output logic [W_ADDR-1:0]            HADDR,
  output logic                         HWRITE,
  output logic [W_DATA-1:0]            HWDATA,
  output logic                         HREADY,
  output logic [1:0]                   HRESP,
  output logic [W_DATA-1:0]            HRDATA,
  output logic [N_MASTER-1:0]          HSPLIT
);

  // Slave index space includes one extra code for the internal default slave.
  localparam int                W_SIDX     = $clog2(N_SLAVE + 1);
  localparam logic [W_SIDX-1:0] DEF_SLV    = W_SIDX'(N_SLAVE);
  localparam logic [1:0]        RESP_OKAY  = 2'b00;
  localparam logic [1:0]        RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  logic [W_MASTER-1:0] dp_master;
  logic [W_SIDX-1:0]   dp_slave;
  logic                dp_req;
  logic [W_SIDX-1:0]   dec_idx;
  logic                dec_hit;
  logic                ds_start;
  ds_state_t           ds_state;
  logic                ds_hready;
  logic [1:0]          ds_hresp;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    HTRANS = 2'b00;
    HBURST = '0;
    HSIZE  = '0;
    HADDR  = '0;
    HWRITE = 1'b0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (HMASTER == W_MASTER'(i)) begin
        HTRANS = m_HTRANS[2*i +: 2];
        HBURST = m_HBURST[3*i +: 3];
        HSIZE  = m_HSIZE[3*i +: 3];
        HADDR  = m_HADDR[W_ADDR*i +: W_ADDR];
        HWRITE = m_HWRITE[i];
      end
    end
  end

  // Lowest matching index wins; the hit flag stops later overlapping regions from claiming it.
  always_comb begin
    dec_idx = DEF_SLV;
    dec_hit = 1'b0;
    HSEL    = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (!dec_hit &&
          ((HADDR & SLV_MASK[W_ADDR*i +: W_ADDR]) == SLV_BASE[W_ADDR*i +: W_ADDR])) begin
        dec_hit = 1'b1;
        dec_idx = W_SIDX'(i);
        HSEL[i] = 1'b1;
      end
    end
  end

  assign ds_start = HTRANS[1] & ~dec_hit;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_master <= '0;
      dp_slave  <= DEF_SLV;
      dp_req    <= 1'b0;
    end else if (HREADY) begin
      dp_master <= HMASTER;
      dp_slave  <= dec_idx;
      dp_req    <= ds_start;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ds_state  <= DS_IDLE;
      ds_hready <= 1'b1;
      ds_hresp  <= RESP_OKAY;
    end else begin
      case (ds_state)
        DS_ERR1: begin
          ds_state  <= DS_ERR2;
          ds_hready <= 1'b1;
          ds_hresp  <= RESP_ERROR;
        end
        DS_IDLE, DS_ERR2: begin
          if (HREADY && ds_start) begin
            ds_state  <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= RESP_ERROR;
          end else begin
            ds_state  <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= RESP_OKAY;
          end
        end
        default: begin
          ds_state  <= DS_IDLE;
          ds_hready <= 1'b1;
          ds_hresp  <= RESP_OKAY;
        end
      endcase
    end
  end

  always_comb begin
    HWDATA = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (dp_master == W_MASTER'(i)) HWDATA = m_HWDATA[W_DATA*i +: W_DATA];
    end
  end

  // A wait state from the default slave only ever belongs to an accepted unmapped transfer.
  always_comb begin
    HREADY = ds_hready | ~dp_req;
    HRESP  = ds_hresp;
    HRDATA = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (dp_slave == W_SIDX'(i)) begin
        HREADY = s_HREADY[i];
        HRESP  = s_HRESP[2*i +: 2];
        HRDATA = s_HRDATA[W_DATA*i +: W_DATA];
      end
    end
  end

`ifdef AHB_SPLIT_EN
  logic [N_MASTER-1:0] split_or;

  always_comb begin
    split_or = '0;
    for (int i = 0; i < N_SLAVE; i++) split_or |= s_HSPLIT[N_MASTER*i +: N_MASTER];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) HSPLIT <= '0;
    else          HSPLIT <= split_or;
  end
`else
  logic unused_split;
  assign unused_split = ^s_HSPLIT;
  assign HSPLIT       = '0;
`endif

endmodule

// File: tb/tb_ahb_interconnect_p.sv
// Self-checking bench for ahb_interconnect_p: directed scenarios plus random traffic compared
// every cycle against a transaction-level reference model.
module tb_ahb_interconnect_p;

  localparam int NM = 3;
  localparam int WM = 2;
  localparam int NS = 8;
  localparam int WA = 32;
  localparam int WD = 32;

  // Slaves 0..6 at 0x1000..0x7FFF (4 KiB each); slave 7 overlaps 0x2000..0x3FFF and never wins.
  localparam logic [NS*WA-1:0] BASE = {32'h0000_2000, 32'h0000_7000, 32'h0000_6000,
                                       32'h0000_5000, 32'h0000_4000, 32'h0000_3000,
                                       32'h0000_2000, 32'h0000_1000};
  localparam logic [NS*WA-1:0] MASK = {32'hFFFF_E000, {7{32'hFFFF_F000}}};

`ifdef AHB_SPLIT_EN
  localparam logic [NM-1:0] SPLIT_EXP = 3'b101;
`else
  localparam logic [NM-1:0] SPLIT_EXP = 3'b000;
`endif

  logic              HCLK;
  logic              HRESETn;
  logic [WM-1:0]     HMASTER;
  logic [2*NM-1:0]   m_HTRANS;
  logic [3*NM-1:0]   m_HBURST;
  logic [3*NM-1:0]   m_HSIZE;
  logic [WA*NM-1:0]  m_HADDR;
  logic [NM-1:0]     m_HWRITE;
  logic [WD*NM-1:0]  m_HWDATA;
  logic [NS-1:0]     s_HREADY;
  logic [2*NS-1:0]   s_HRESP;
  logic [WD*NS-1:0]  s_HRDATA;
  logic [NM*NS-1:0]  s_HSPLIT;
  logic [NS-1:0]     HSEL;
  logic [1:0]        HTRANS;
  logic [2:0]        HBURST;
  logic [2:0]        HSIZE;
  logic [WA-1:0]     HADDR;
  logic              HWRITE;
  logic [WD-1:0]     HWDATA;
  logic              HREADY;
  logic [1:0]        HRESP;
  logic [WD-1:0]     HRDATA;
  logic [NM-1:0]     HSPLIT;

  ahb_interconnect_p #(
    .N_MASTER(NM), .W_MASTER(WM), .N_SLAVE(NS), .W_ADDR(WA), .W_DATA(WD),
    .SLV_BASE(BASE), .SLV_MASK(MASK)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HMASTER(HMASTER),
    .m_HTRANS(m_HTRANS), .m_HBURST(m_HBURST), .m_HSIZE(m_HSIZE), .m_HADDR(m_HADDR),
    .m_HWRITE(m_HWRITE), .m_HWDATA(m_HWDATA),
    .s_HREADY(s_HREADY), .s_HRESP(s_HRESP), .s_HRDATA(s_HRDATA), .s_HSPLIT(s_HSPLIT),
    .HSEL(HSEL), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HADDR(HADDR),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HSPLIT(HSPLIT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: address map as arrays, data phase as plain numbers, default-slave
  // responses as a queue of pending (ready, resp) beats.
  typedef struct packed {logic rdy; logic [1:0] resp;} rsp_t;

  logic [31:0] base_arr [NS] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000,
                                 32'h5000, 32'h6000, 32'h7000, 32'h2000};
  logic [31:0] mask_arr [NS] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
                                 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000};

  int          md_master;
  int          md_slave;
  rsp_t        err_q[$];
  logic [NM-1:0] m_split;
  bit          armed = 1'b0;

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & mask_arr[i]) == base_arr[i]) return i;
    return NS;
  endfunction

  // One bus cycle: check outputs just after the inputs settle, then advance the model at the edge.
  task automatic step();
    int          hm;
    int          e_dec;
    logic [1:0]  e_trans;
    logic [2:0]  e_burst, e_size;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_write, e_rdy;
    logic [1:0]  e_resp;
    logic [NS-1:0] e_hsel;
    logic [NM-1:0] e_split;
    #1;
    hm = int'(HMASTER);
    if (hm < NM) begin
      e_trans = m_HTRANS[hm*2 +: 2];
      e_burst = m_HBURST[hm*3 +: 3];
      e_size  = m_HSIZE[hm*3 +: 3];
      e_addr  = m_HADDR[hm*WA +: WA];
      e_write = m_HWRITE[hm];
    end else begin
      e_trans = 2'b00; e_burst = 3'b0; e_size = 3'b0; e_addr = '0; e_write = 1'b0;
    end
    e_dec   = ref_decode(e_addr);
    e_hsel  = (e_dec < NS) ? (NS'(1) << e_dec) : '0;
    e_wdata = (md_master < NM) ? m_HWDATA[md_master*WD +: WD] : '0;
    if (md_slave < NS) begin
      e_rdy   = s_HREADY[md_slave];
      e_resp  = s_HRESP[md_slave*2 +: 2];
      e_rdata = s_HRDATA[md_slave*WD +: WD];
    end else begin
      e_rdy   = (err_q.size() > 0) ? err_q[0].rdy  : 1'b1;
      e_resp  = (err_q.size() > 0) ? err_q[0].resp : 2'b00;
      e_rdata = '0;
    end
`ifdef AHB_SPLIT_EN
    e_split = m_split;
`else
    e_split = '0;
`endif
    if (armed) begin
      check("addr_ctrl", {HTRANS, HBURST, HSIZE, HWRITE, HADDR},
                         {e_trans, e_burst, e_size, e_write, e_addr});
      check("hsel",   HSEL,   e_hsel);
      check("hwdata", HWDATA, e_wdata);
      check("rdy_resp", {HREADY, HRESP}, {e_rdy, e_resp});
      check("hrdata", HRDATA, e_rdata);
      check("hsplit", HSPLIT, e_split);
    end
    @(posedge HCLK);
    if (!HRESETn) begin
      md_master = 0;
      md_slave  = NS;
      err_q.delete();
      m_split   = '0;
      armed     = 1'b1;
    end else begin
      if (err_q.size() > 0) void'(err_q.pop_front());
      if (e_rdy) begin
        md_master = hm;
        md_slave  = e_dec;
        if (e_trans[1] && e_dec == NS) begin
          err_q.push_back({1'b0, 2'b01});
          err_q.push_back({1'b1, 2'b01});
        end
      end
      m_split = '0;
      for (int i = 0; i < NS; i++) m_split |= s_HSPLIT[i*NM +: NM];
    end
    @(negedge HCLK);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'hF000_0000;
      1:       return $urandom();
      default: return {16'h0, 4'($urandom_range(0, 9)), 12'($urandom())};
    endcase
  endfunction

  task automatic drive_random();
    HRESETn = ($urandom_range(0, 49) != 0);
    HMASTER = WM'($urandom_range(0, 3));
    for (int i = 0; i < NM; i++) begin
      m_HTRANS[i*2 +: 2] = 2'($urandom());
      m_HBURST[i*3 +: 3] = 3'($urandom());
      m_HSIZE[i*3 +: 3]  = 3'($urandom());
      m_HADDR[i*WA +: WA] = rand_addr();
      m_HWRITE[i]        = 1'($urandom());
      m_HWDATA[i*WD +: WD] = $urandom();
    end
    for (int i = 0; i < NS; i++) begin
      s_HREADY[i]          = ($urandom_range(0, 3) != 0);
      s_HRESP[i*2 +: 2]    = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00;
      s_HRDATA[i*WD +: WD] = $urandom();
      s_HSPLIT[i*NM +: NM] = ($urandom_range(0, 7) == 0) ? NM'($urandom()) : '0;
    end
  endtask

  initial begin
    HRESETn = 1'b0; HMASTER = '0;
    m_HTRANS = '0; m_HBURST = '0; m_HSIZE = '0; m_HADDR = '0; m_HWRITE = '0; m_HWDATA = '0;
    s_HREADY = '1; s_HRESP = '0; s_HRDATA = '0; s_HSPLIT = '0;
    @(negedge HCLK);
    step();
    step();

    // Reset release: default slave idle, decode follows master 0.
    HRESETn = 1'b1;
    m_HADDR[0 +: WA] = 32'h0000_1004;
    #1;
    check("rst_rdy_resp", {HREADY, HRESP}, 3'b1_00);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hsel", HSEL, 8'b0000_0001);
    step();

    // Master 2 writes slave 1; data phase holds through three slave wait states.
    HMASTER = 2'd2;
    m_HTRANS[4 +: 2] = 2'b10;
    m_HWRITE[2] = 1'b1;
    m_HADDR[2*WA +: WA] = 32'h0000_2004;
    m_HWDATA[2*WD +: WD] = 32'hA5A5_0001;
    m_HWDATA[0 +: WD] = 32'h1111_1111;
    #1;
    check("wr_hsel", HSEL, 8'b0000_0010);
    step();
    HMASTER = 2'd0;
    m_HTRANS = '0;
    s_HREADY[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) HMASTER = WM'(k);
      #1;
      check("wait_hready", HREADY, 1'b0);
      check("wait_hwdata", HWDATA, 32'hA5A5_0001);
      step();
    end
    s_HREADY[1] = 1'b1;
    #1;
    check("done_hready", HREADY, 1'b1);
    check("done_hwdata", HWDATA, 32'hA5A5_0001);
    step();

    // Unmapped NONSEQ read: two-cycle ERROR, then an IDLE to the same address is OKAY.
    HMASTER = 2'd0;
    m_HTRANS[0 +: 2] = 2'b10;
    m_HWRITE[0] = 1'b0;
    m_HADDR[0 +: WA] = 32'hF000_0000;
    #1;
    check("unm_hsel", HSEL, 8'h00);
    step();
    m_HTRANS[0 +: 2] = 2'b00;
    #1; check("err1", {HREADY, HRESP}, 3'b0_01); step();
    #1; check("err2", {HREADY, HRESP}, 3'b1_01); step();
    #1; check("idle_okay", {HREADY, HRESP}, 3'b1_00); step();
    #1; check("idle_zero_wait", {HREADY, HRESP}, 3'b1_00); step();

    // Back-to-back unmapped NONSEQ: second sampled in ERR2, pairs run without a gap.
    m_HTRANS[0 +: 2] = 2'b10;
    step();
    #1; check("b2b_err1a", {HREADY, HRESP}, 3'b0_01); step();
    #1; check("b2b_err2a", {HREADY, HRESP}, 3'b1_01); step();
    m_HTRANS[0 +: 2] = 2'b00;
    #1; check("b2b_err1b", {HREADY, HRESP}, 3'b0_01); step();
    #1; check("b2b_err2b", {HREADY, HRESP}, 3'b1_01); step();
    #1; check("b2b_okay", {HREADY, HRESP}, 3'b1_00); step();

    // Split vectors from slaves 3 and 5 combine one cycle later.
    s_HSPLIT[3*NM +: NM] = 3'b100;
    s_HSPLIT[5*NM +: NM] = 3'b001;
    step();
    s_HSPLIT = '0;
    #1;
    check("split_or", HSPLIT, SPLIT_EXP);
    step();

    for (int n = 0; n < 1500; n++) begin
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
